regfile: RTL and testbench

//  Parametrised multi-port register file; the successor to the single enabled register.

---
 rtl/regfile.sv | 66 ++++++
 tb/tb_regfile.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// Register file with WIDTH-bit words, DEPTH entries, one synchronous write port and NUM_READ combinational read ports.
// Configuration macro: REGFILE_BYPASS_EN enables same-cycle write-through forwarding to the read ports.
module regfile #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_READ = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr [NUM_READ],
    output logic [WIDTH-1:0] rd_data [NUM_READ]
);
    localparam int          AWP1    = AW + 1;
    localparam logic [AW:0] DEPTH_W = AWP1'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_ok;

    // An address is live when it maps to real storage: in range and not the hardwired zero entry.
    function automatic logic addr_live(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_ok = wr_en && addr_live(wr_addr);

    always_comb begin
        mem_d = mem_q;
        for (int j = 0; j < DEPTH; j++) begin
            if (wr_ok && (wr_addr == AW'(j))) begin
                mem_d[j] = wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Dead addresses fall through to zero, so out-of-range and x0 reads never see storage.
    always_comb begin
        for (int i = 0; i < NUM_READ; i++) begin
            rd_data[i] = '0;
            for (int j = 0; j < DEPTH; j++) begin
                if (addr_live(rd_addr[i]) && (rd_addr[i] == AW'(j))) begin
                    rd_data[i] = mem_q[j];
                end
            end
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && !rst && (rd_addr[i] == wr_addr)) begin
                rd_data[i] = wr_data;
            end
`else
`endif
        end
    end
endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: a 32-entry two-port instance and a 24-entry one-port instance.
module tb_regfile;
    localparam int W  = 32;
    localparam int D  = 32;
    localparam int NR = 2;
    localparam int AW = 5;
    localparam int D2 = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;
    logic [AW-1:0] rd_addr [NR];
    logic [W-1:0]  rd_data [NR];

    logic          wr_en2;
    logic [AW-1:0] wr_addr2;
    logic [AW-1:0] rd_addr2 [1];
    logic [W-1:0]  rd_data2 [1];

    logic [W-1:0]  mdl  [D];
    logic [W-1:0]  mdl2 [D2];
    logic [W-1:0]  exp_q [$];
    string         tag_q [$];

    int total = 0;
    int bad   = 0;

    regfile #(.WIDTH(W), .DEPTH(D), .NUM_READ(NR), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    regfile #(.WIDTH(W), .DEPTH(D2), .NUM_READ(1), .ZERO_REG(1)) u_dut24 (
        .clk(clk), .rst(rst), .wr_en(wr_en2), .wr_addr(wr_addr2),
        .wr_data(wr_data), .rd_addr(rd_addr2), .rd_data(rd_data2)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_rd(input logic [AW-1:0] a);
        logic [W-1:0] v;
        v = (a == '0) ? '0 : mdl[a];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && !rst && a == wr_addr && a != '0) v = wr_data;
`endif
        return v;
    endfunction

    function automatic logic [W-1:0] exp_rd2(input logic [AW-1:0] a);
        logic [W-1:0] v;
        v = (int'(a) < D2 && a != '0) ? mdl2[a] : '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en2 && !rst && a == wr_addr2 && a != '0 && int'(a) < D2) v = wr_data;
`endif
        return v;
    endfunction

    // One clock: queue expectations for the current inputs, compare mid-cycle, then advance the model.
    task automatic step(input string tag);
        for (int p = 0; p < NR; p++) begin
            exp_q.push_back(exp_rd(rd_addr[p]));
            tag_q.push_back($sformatf("%s.p%0d.a%0d", tag, p, rd_addr[p]));
        end
        exp_q.push_back(exp_rd2(rd_addr2[0]));
        tag_q.push_back($sformatf("%s.d24.a%0d", tag, rd_addr2[0]));
        @(negedge clk);
        for (int p = 0; p < NR; p++) chk(tag_q.pop_front(), rd_data[p], exp_q.pop_front());
        chk(tag_q.pop_front(), rd_data2[0], exp_q.pop_front());
        @(posedge clk);
        if (rst) begin
            for (int j = 0; j < D; j++) mdl[j] = '0;
            for (int j = 0; j < D2; j++) mdl2[j] = '0;
        end else begin
            if (wr_en && wr_addr != '0) mdl[wr_addr] = wr_data;
            if (wr_en2 && wr_addr2 != '0 && int'(wr_addr2) < D2) mdl2[wr_addr2] = wr_data;
        end
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        wr_en2 = 1'b0; wr_addr2 = '0; rd_addr2[0] = '0;
        for (int p = 0; p < NR; p++) rd_addr[p] = '0;
        @(posedge clk); #1;
        for (int j = 0; j < D; j++) mdl[j] = '0;
        for (int j = 0; j < D2; j++) mdl2[j] = '0;
        rst = 1'b0;

        // reset clears a written entry; rst wins over a concurrent write
        wr(5, 32'hDEADBEEF); rd_addr[0] = 5; rd_addr[1] = 5;
        step("wr_x5");
        wr_en = 1'b0;
        step("rd_x5");
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wr(5, 32'hCAFEF00D);
            step("rst_hold");
        end
        rst = 1'b0; wr_en = 1'b0;
        for (int a = 0; a < D; a++) begin
            rd_addr[0] = AW'(a); rd_addr[1] = AW'(D - 1 - a); rd_addr2[0] = AW'(a);
            step("post_rst");
        end

        // directed writes then random data everywhere, read back a cycle later on both ports
        wr(1, 32'h0); rd_addr[0] = 1; rd_addr[1] = 1;
        step("wr_x1");
        wr(31, 32'hFFFFFFFF);
        step("wr_x31");
        wr_en = 1'b0; rd_addr[0] = 31; rd_addr[1] = 31;
        step("rd_x31");
        for (int a = 0; a < D; a++) begin
            wr(AW'(a), $urandom);
            rd_addr[0] = AW'((a + D - 1) % D); rd_addr[1] = rd_addr[0];
            step("wr_all");
        end
        wr_en = 1'b0; rd_addr[0] = 31; rd_addr[1] = 31;
        step("rd_last");

        // x0 is hardwired to zero
        wr(0, 32'h12345678); rd_addr[0] = 0; rd_addr[1] = 0;
        step("wr_x0");
        wr_en = 1'b0;
        step("rd_x0");

        // same-address read during write
        wr(7, 32'hA); rd_addr[0] = 3; rd_addr[1] = 3;
        step("wr_x7_a");
        wr(7, 32'hB); rd_addr[0] = 7; rd_addr[1] = 7;
        step("rw_x7");
        wr_en = 1'b0;
        step("rd_x7");

        // 24-entry instance: out-of-range write is dropped and reads zero; top entry is normal
        wr_en2 = 1'b1; wr_addr2 = 27; wr_data = 32'h55; rd_addr2[0] = 27;
        step("d24_wr27");
        wr_en2 = 1'b0;
        step("d24_rd27");
        for (int a = 0; a < D2; a++) begin
            rd_addr2[0] = AW'(a);
            step("d24_scan");
        end
        wr_en2 = 1'b1; wr_addr2 = 23; wr_data = 32'h5A5A1234; rd_addr2[0] = 23;
        step("d24_wr23");
        wr_en2 = 1'b0;
        step("d24_rd23");

        // random traffic with occasional reset, against the model
        for (int k = 0; k < 10000; k++) begin
            rst      = ($urandom_range(15) == 0);
            wr_en    = ($urandom_range(1) == 1);
            wr_addr  = AW'($urandom_range(D - 1));
            wr_data  = $urandom;
            wr_en2   = ($urandom_range(1) == 1);
            wr_addr2 = AW'($urandom_range(31));
            for (int p = 0; p < NR; p++)
                rd_addr[p] = ($urandom_range(3) == 0) ? wr_addr : AW'($urandom_range(D - 1));
            rd_addr2[0] = ($urandom_range(3) == 0) ? wr_addr2 : AW'($urandom_range(31));
            step("rand");
        end
        rst = 1'b0; wr_en = 1'b0; wr_en2 = 1'b0;
        for (int a = 0; a < D; a++) begin
            rd_addr[0] = AW'(a); rd_addr[1] = AW'(a); rd_addr2[0] = AW'(a);
            step("final_scan");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
